video_pattern_gen: RTL

//  AXI4-Stream video source; generates synthetic frames (TUSER[0]=SOF, TLAST=EOL).

---
 rtl/video_pattern_gen.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: AXI4-Stream synthetic video source.
// Emits frames of h_size x v_size pixels, TUSER[0] = start of frame, TLAST = end of line.
// Geometry, pattern and inter-frame gap are latched at every frame start.
// Optional feature macro: VIDEO_PATGEN_COLORBAR_EN (pattern 3 = eight colour bars);
// without it pattern 3 repeats the x-ramp and no bar logic exists.
module video_pattern_gen #(
  parameter int DATA_W = 24,
  parameter int SIZE_W = 12,
  parameter int GAP_W  = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              gen_en_i,
  input  logic [1:0]        pattern_sel_i,
  input  logic [SIZE_W-1:0] h_size_i,
  input  logic [SIZE_W-1:0] v_size_i,
  input  logic [GAP_W-1:0]  frame_gap_i,
  output logic [DATA_W-1:0] m_tdata_o,
  output logic              m_tvalid_o,
  input  logic              m_tready_i,
  output logic              m_tuser_o,
  output logic              m_tlast_o,
  output logic [7:0]        frames_cnt_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, GAP = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [SIZE_W-1:0] x, x_nxt, y, y_nxt;
  logic [SIZE_W-1:0] h_cfg, h_cfg_nxt, v_cfg, v_cfg_nxt;
  logic [GAP_W-1:0]  gap_cfg, gap_cfg_nxt, gap_cnt, gap_cnt_nxt;
  logic [1:0]        pat_cfg, pat_cfg_nxt;
  logic [7:0]        frames, frames_nxt;
  logic [DATA_W-1:0] tdata, tdata_nxt;
  logic              tvalid, tvalid_nxt, tuser, tuser_nxt, tlast, tlast_nxt;
  logic              busy, busy_nxt;
  logic              start_frame, present;

`ifdef VIDEO_PATGEN_COLORBAR_EN
  // Bar index tracks floor(8*x/H) incrementally: acc holds the remainder 8*x mod H.
  logic [2:0]        bar, bar_nxt;
  logic [SIZE_W+3:0] acc, acc_nxt;

  function automatic logic [23:0] bar_colour(input logic [2:0] b);
    case (b)
      3'd0:    bar_colour = 24'hFFFFFF;  // white
      3'd1:    bar_colour = 24'hFFFF00;  // yellow
      3'd2:    bar_colour = 24'h00FFFF;  // cyan
      3'd3:    bar_colour = 24'h00FF00;  // green
      3'd4:    bar_colour = 24'hFF00FF;  // magenta
      3'd5:    bar_colour = 24'hFF0000;  // red
      3'd6:    bar_colour = 24'h0000FF;  // blue
      default: bar_colour = 24'h000000;  // black
    endcase
  endfunction

  // One x step: add 8 to the remainder and carry whole multiples of H into the bar index.
  // For H < 8 several carries can happen in one step, hence the bounded unrolled loop.
  function automatic logic [SIZE_W+6:0] bar_step(input logic [SIZE_W+3:0] a_in,
                                                 input logic [2:0] b_in,
                                                 input logic [SIZE_W-1:0] h);
    logic [SIZE_W+3:0] a;
    logic [2:0]        b;
    a = a_in + (SIZE_W+4)'(8);
    b = b_in;
    for (int k = 0; k < 8; k++) begin
      if (a >= {4'b0000, h}) begin
        a = a - {4'b0000, h};
        b = b + 3'd1;
      end else begin
        a = a;
      end
    end
    bar_step = {a, b};
  endfunction

  function automatic logic [23:0] pixel(input logic [1:0] pat, input logic [7:0] px,
                                        input logic [7:0] py, input logic [7:0] fc,
                                        input logic [2:0] b);
    case (pat)
      2'd0:    pixel = {px, px, px};
      2'd1:    pixel = {fc, py, px};
      2'd2:    pixel = (px[3] ^ py[3]) ? 24'hFFFFFF : 24'h000000;
      default: pixel = bar_colour(b);
    endcase
  endfunction
`else
  function automatic logic [23:0] pixel(input logic [1:0] pat, input logic [7:0] px,
                                        input logic [7:0] py, input logic [7:0] fc);
    case (pat)
      2'd1:    pixel = {fc, py, px};
      2'd2:    pixel = (px[3] ^ py[3]) ? 24'hFFFFFF : 24'h000000;
      default: pixel = {px, px, px};
    endcase
  endfunction
`endif

  // Next-state, counters and next registered beat (held while stalled).
  always_comb begin
    state_nxt   = state;
    x_nxt       = x;
    y_nxt       = y;
    h_cfg_nxt   = h_cfg;
    v_cfg_nxt   = v_cfg;
    gap_cfg_nxt = gap_cfg;
    gap_cnt_nxt = gap_cnt;
    pat_cfg_nxt = pat_cfg;
    frames_nxt  = frames;
    tdata_nxt   = tdata;
    tvalid_nxt  = tvalid;
    tuser_nxt   = tuser;
    tlast_nxt   = tlast;
    start_frame = 1'b0;
    present     = 1'b0;
`ifdef VIDEO_PATGEN_COLORBAR_EN
    bar_nxt     = bar;
    acc_nxt     = acc;
`endif

    case (state)
      IDLE: begin
        if (gen_en_i) begin
          start_frame = 1'b1;
        end else begin
          tvalid_nxt = 1'b0;
        end
      end
      ACTIVE: begin
        if (tvalid && m_tready_i) begin
          if (x == h_cfg - SIZE_W'(1)) begin
            x_nxt = {SIZE_W{1'b0}};
`ifdef VIDEO_PATGEN_COLORBAR_EN
            bar_nxt = 3'd0;
            acc_nxt = {(SIZE_W+4){1'b0}};
`endif
            if (y == v_cfg - SIZE_W'(1)) begin
              frames_nxt = frames + 8'd1;
              if (gap_cfg != {GAP_W{1'b0}}) begin
                state_nxt   = GAP;
                gap_cnt_nxt = gap_cfg;
              end else if (gen_en_i) begin
                start_frame = 1'b1;
              end else begin
                state_nxt = IDLE;
              end
              tvalid_nxt = 1'b0;
              tuser_nxt  = 1'b0;
              tlast_nxt  = 1'b0;
              tdata_nxt  = {DATA_W{1'b0}};
            end else begin
              y_nxt   = y + SIZE_W'(1);
              present = 1'b1;
            end
          end else begin
            x_nxt   = x + SIZE_W'(1);
            present = 1'b1;
`ifdef VIDEO_PATGEN_COLORBAR_EN
            {acc_nxt, bar_nxt} = bar_step(acc, bar, h_cfg);
`endif
          end
        end else begin
          tvalid_nxt = tvalid;
        end
      end
      GAP: begin
        if (gap_cnt > GAP_W'(1)) begin
          gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end else if (gen_en_i) begin
          start_frame = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        tvalid_nxt = 1'b0;
        tuser_nxt  = 1'b0;
        tlast_nxt  = 1'b0;
        tdata_nxt  = {DATA_W{1'b0}};
      end
    endcase

    // A new frame latches the configuration and presents pixel (0,0) immediately.
    if (start_frame) begin
      state_nxt   = ACTIVE;
      h_cfg_nxt   = (h_size_i == {SIZE_W{1'b0}}) ? SIZE_W'(1) : h_size_i;
      v_cfg_nxt   = (v_size_i == {SIZE_W{1'b0}}) ? SIZE_W'(1) : v_size_i;
      gap_cfg_nxt = frame_gap_i;
      pat_cfg_nxt = pattern_sel_i;
      gap_cnt_nxt = {GAP_W{1'b0}};
      x_nxt       = {SIZE_W{1'b0}};
      y_nxt       = {SIZE_W{1'b0}};
      present     = 1'b1;
`ifdef VIDEO_PATGEN_COLORBAR_EN
      bar_nxt     = 3'd0;
      acc_nxt     = {(SIZE_W+4){1'b0}};
`endif
    end else begin
      start_frame = 1'b0;
    end

    if (present) begin
      tvalid_nxt = 1'b1;
      tuser_nxt  = (x_nxt == {SIZE_W{1'b0}}) && (y_nxt == {SIZE_W{1'b0}});
      tlast_nxt  = (x_nxt == h_cfg_nxt - SIZE_W'(1));
`ifdef VIDEO_PATGEN_COLORBAR_EN
      tdata_nxt  = DATA_W'(pixel(pat_cfg_nxt, x_nxt[7:0], y_nxt[7:0], frames_nxt, bar_nxt));
`else
      tdata_nxt  = DATA_W'(pixel(pat_cfg_nxt, x_nxt[7:0], y_nxt[7:0], frames_nxt));
`endif
    end else begin
      present = 1'b0;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs; asynchronous reset returns everything to zero.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= IDLE;
      x       <= {SIZE_W{1'b0}};
      y       <= {SIZE_W{1'b0}};
      h_cfg   <= {SIZE_W{1'b0}};
      v_cfg   <= {SIZE_W{1'b0}};
      gap_cfg <= {GAP_W{1'b0}};
      gap_cnt <= {GAP_W{1'b0}};
      pat_cfg <= 2'd0;
      frames  <= 8'd0;
      tdata   <= {DATA_W{1'b0}};
      tvalid  <= 1'b0;
      tuser   <= 1'b0;
      tlast   <= 1'b0;
      busy    <= 1'b0;
`ifdef VIDEO_PATGEN_COLORBAR_EN
      bar     <= 3'd0;
      acc     <= {(SIZE_W+4){1'b0}};
`endif
    end else begin
      state   <= state_nxt;
      x       <= x_nxt;
      y       <= y_nxt;
      h_cfg   <= h_cfg_nxt;
      v_cfg   <= v_cfg_nxt;
      gap_cfg <= gap_cfg_nxt;
      gap_cnt <= gap_cnt_nxt;
      pat_cfg <= pat_cfg_nxt;
      frames  <= frames_nxt;
      tdata   <= tdata_nxt;
      tvalid  <= tvalid_nxt;
      tuser   <= tuser_nxt;
      tlast   <= tlast_nxt;
      busy    <= busy_nxt;
`ifdef VIDEO_PATGEN_COLORBAR_EN
      bar     <= bar_nxt;
      acc     <= acc_nxt;
`endif
    end
  end

  assign m_tdata_o    = tdata;
  assign m_tvalid_o   = tvalid;
  assign m_tuser_o    = tuser;
  assign m_tlast_o    = tlast;
  assign frames_cnt_o = frames;
  assign busy_o       = busy;

endmodule
